// File: rtl/death_anim_addr.sv
// Death-animation sprite addressing: maps the current pixel into a 64x64 frame
// of a multi-frame sprite ROM and sequences the frames on video-frame ticks.
module death_anim_addr #(
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 64,
  parameter int N_FRAMES    = 4,
  parameter int FRAME_TICKS = 8
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        frame_start,
  input  logic        trigger,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  output logic [13:0] rom_address,
  output logic        in_sprite,
  output logic        busy,
  output logic        done
);

  localparam int            TW         = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [1:0]    LAST_FRAME = 2'(N_FRAMES - 1);
  localparam logic [10:0]   X_SPAN     = 11'(SPR_W - 1);
  localparam logic [10:0]   Y_SPAN     = 11'(SPR_H - 1);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

  state_t        r_state;
  logic [1:0]    r_frame_idx;
  logic [TW-1:0] r_tick;
  logic          r_busy;
  logic          r_done;
  logic [13:0]   r_rom_address;
  logic          r_in_sprite;

  // Bounds are compared in 11 bits so a sprite near the right/bottom edge
  // never wraps its far edge back to small coordinates.
  logic [10:0] w_x, w_y, w_sx, w_sy;
  logic        w_in_x, w_in_y, w_inside;
  logic [5:0]  w_col, w_row;
  logic [1:0]  w_next_frame;

  assign w_x      = {1'b0, DrawX};
  assign w_y      = {1'b0, DrawY};
  assign w_sx     = {1'b0, sprite_x};
  assign w_sy     = {1'b0, sprite_y};
  assign w_in_x   = (w_x >= w_sx) && (w_x <= w_sx + X_SPAN);
  assign w_in_y   = (w_y >= w_sy) && (w_y <= w_sy + Y_SPAN);
  assign w_inside = w_in_x && w_in_y;
  // Only the low six bits of the offset matter once the pixel is inside.
  assign w_col    = DrawX[5:0] - sprite_x[5:0];
  assign w_row    = DrawY[5:0] - sprite_y[5:0];

  assign w_next_frame = r_frame_idx + 2'd1;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_in_sprite   <= 1'b0;
      r_rom_address <= '0;
    end else begin
      r_in_sprite   <= w_inside;
      r_rom_address <= w_inside ? {r_frame_idx, w_row, w_col} : '0;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_frame_idx <= '0;
      r_tick      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_frame_idx <= '0;
          r_tick      <= '0;
          if (trigger) begin
            r_state <= PLAY;
            r_busy  <= 1'b1;
          end
        end
        PLAY: begin
          if (frame_start) begin
            if (r_tick == TICK_LAST) begin
              r_tick <= '0;
              if (N_FRAMES == 1) begin
                r_state <= HOLD;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_frame_idx <= w_next_frame;
                if (w_next_frame == LAST_FRAME) begin
                  r_state <= HOLD;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end
        HOLD: begin
          // Restart wins over any frame_start seen in the same cycle.
          if (trigger) begin
            r_state     <= PLAY;
            r_busy      <= 1'b1;
            r_frame_idx <= '0;
            r_tick      <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_frame_idx <= '0;
          r_tick      <= '0;
        end
      endcase
    end
  end

  assign rom_address = r_rom_address;
  assign in_sprite   = r_in_sprite;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_death_anim_addr.sv
// Scoreboard bench for death_anim_addr: pixel expectations are queued on drive
// and compared one cycle later against a bench-side frame/tick model.
module tb_death_anim_addr;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
  logic        frame_start, trigger;
  logic [13:0] rom_address;
  logic        in_sprite, busy, done;

  int total = 0;
  int bad   = 0;
  int exp_frame = 0;
  int exp_tick  = 0;
  logic [14:0] sb_q[$];

  always #5 vga_clk = ~vga_clk;

  death_anim_addr dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .trigger(trigger),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .rom_address(rom_address), .in_sprite(in_sprite), .busy(busy), .done(done)
  );

  function automatic logic [14:0] model_pix(int x, int y, int sx, int sy, int fr);
    int dx, dy;
    dx = x - sx;
    dy = y - sy;
    if (dx >= 0 && dx < 64 && dy >= 0 && dy < 64)
      return {1'b1, 14'(fr * 4096 + dy * 64 + dx)};
    return 15'd0;
  endfunction

  task automatic check_pix(input int x, input int y, input string name);
    logic [14:0] e, got;
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    sb_q.push_back(model_pix(x, y, int'(sprite_x), int'(sprite_y), exp_frame));
    @(posedge vga_clk);
    #1;
    got = {in_sprite, rom_address};
    e = sb_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s (%0d,%0d): got in=%b addr=%0d, want in=%b addr=%0d",
               name, x, y, got[14], got[13:0], e[14], e[13:0]);
    end
  endtask

  task automatic check_flags(input logic eb, input logic ed, input string name);
    total++;
    if (busy !== eb || done !== ed) begin
      bad++;
      $display("FAIL %s: got busy=%b done=%b, want busy=%b done=%b", name, busy, done, eb, ed);
    end
  endtask

  // One-cycle frame_start; flags are sampled just after the counting edge.
  task automatic pulse_fs(input logic eb, input logic ed, input string name);
    @(negedge vga_clk);
    frame_start = 1'b1;
    @(posedge vga_clk);
    #1;
    check_flags(eb, ed, name);
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  task automatic model_tick();
    exp_tick++;
    if (exp_tick == 8) begin
      exp_tick = 0;
      if (exp_frame < 3) exp_frame++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; DrawX = 10'd100; DrawY = 10'd50; sprite_x = 10'd100; sprite_y = 10'd50;
    frame_start = 1'b0; trigger = 1'b0;
    #2;
    total++;
    if ({rom_address, in_sprite, busy, done} !== 17'd0) begin
      bad++;
      $display("FAIL reset_state: got addr=%0d in=%b busy=%b done=%b, want all 0",
               rom_address, in_sprite, busy, done);
    end
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b0;
    #1;
    total++;
    if ({rom_address, in_sprite, busy, done} !== 17'd0) begin
      bad++;
      $display("FAIL post_release_hold: got addr=%0d in=%b busy=%b done=%b, want all 0",
               rom_address, in_sprite, busy, done);
    end
  endtask

  task automatic test_inside();
    int xs[7] = '{100, 163, 164,  99, 130, 130, 120};
    int ys[7] = '{ 50, 113, 113,  50,  49, 114,  60};
    sprite_x = 10'd100; sprite_y = 10'd50;
    for (int i = 0; i < 7; i++) check_pix(xs[i], ys[i], "inside_corner");
  endtask

  task automatic test_wrap();
    sprite_x = 10'd1000; sprite_y = 10'd50;
    check_pix(5, 60, "right_edge_wrap");
    check_pix(1023, 60, "right_edge_col23");
    check_pix(1000, 50, "right_edge_origin");
    check_pix(999, 50, "right_edge_left");
  endtask

  task automatic test_anim();
    sprite_x = 10'd100; sprite_y = 10'd50;
    exp_frame = 0; exp_tick = 0;
    @(negedge vga_clk); trigger = 1'b1;
    @(posedge vga_clk); #1;
    check_flags(1'b1, 1'b0, "anim_start");
    @(negedge vga_clk); trigger = 1'b0;
    for (int p = 1; p <= 24; p++) begin
      pulse_fs(p < 24, p == 24, "anim_pulse");
      model_tick();
      check_pix(100, 50, "anim_frame");
      if (p == 10) begin
        // Retrigger while playing must not restart the count.
        @(negedge vga_clk); trigger = 1'b1;
        repeat (3) @(negedge vga_clk);
        trigger = 1'b0;
        check_pix(100, 50, "play_trigger_ignored");
        check_flags(1'b1, 1'b0, "play_trigger_busy");
      end
    end
    check_flags(1'b0, 1'b0, "done_one_cycle");
    for (int p = 0; p < 4; p++) pulse_fs(1'b0, 1'b0, "hold_pulse");
    check_pix(100, 50, "hold_frame");
    check_pix(163, 113, "hold_corner");
  endtask

  task automatic test_restart();
    @(negedge vga_clk); trigger = 1'b1; frame_start = 1'b1;
    @(posedge vga_clk); #1;
    check_flags(1'b1, 1'b0, "restart_flags");
    @(negedge vga_clk); trigger = 1'b0; frame_start = 1'b0;
    exp_frame = 0; exp_tick = 0;
    check_pix(100, 50, "restart_frame0");
    for (int p = 1; p <= 16; p++) begin
      pulse_fs(1'b1, 1'b0, "restart_pulse");
      model_tick();
      if (p == 7 || p == 8 || p == 16) check_pix(100, 50, "restart_tick0");
    end
  endtask

  task automatic test_reset_mid();
    check_pix(100, 50, "pre_reset_frame2");
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({rom_address, in_sprite, busy, done} !== 17'd0) begin
      bad++;
      $display("FAIL reset_mid: got addr=%0d in=%b busy=%b done=%b, want all 0",
               rom_address, in_sprite, busy, done);
    end
    @(negedge vga_clk); reset = 1'b0;
    exp_frame = 0; exp_tick = 0;
    for (int p = 0; p < 10; p++) pulse_fs(1'b0, 1'b0, "reset_idle_pulse");
    check_pix(100, 50, "reset_idle_frame");
  endtask

  initial begin
    test_reset();
    test_inside();
    test_wrap();
    test_anim();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
